// File: rtl/video_timing_gen.sv
// Parametrised HDMI-style raster timing generator with look-ahead pixel requests.
// Optional colour-bar source enabled by VIDEO_TIMING_GEN_TEST_PATTERN_EN (adds pattern_sel).
module video_timing_gen #(
  parameter int unsigned H_ACTIVE  = 1920,
  parameter int unsigned H_FP      = 88,
  parameter int unsigned H_SYNC    = 44,
  parameter int unsigned H_BP      = 148,
  parameter int unsigned V_ACTIVE  = 1080,
  parameter int unsigned V_FP      = 4,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 36,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned LOOKAHEAD = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  input  logic [DATA_W-1:0] pix_in,
  output logic              px_req,
  output logic [CNT_W-1:0]  px_x,
  output logic [CNT_W-1:0]  px_y,
  output logic [DATA_W-1:0] data,
  output logic              data_en,
  output logic              h_sync,
  output logic              v_sync,
  output logic              frame_start,
  output logic              clk_out
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_SW    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SW    = CNT_W'(V_SYNC);

  localparam int unsigned HS_B = 0;
  localparam int unsigned VS_B = 1;
  localparam int unsigned AC_B = 2;
  localparam int unsigned FS_B = 3;
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  localparam int unsigned ST_W = 7;
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
`else
  localparam int unsigned ST_W = 4;
`endif

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic             w_active;
  logic             r_req, r_hs, r_vs, r_fs;
  logic [CNT_W-1:0] r_px_x, r_px_y;
  logic [ST_W-1:0]  w_stage, w_pre, w_out;
  logic [ST_W-1:0]  r_dly [LOOKAHEAD];
  logic [DATA_W-1:0] w_pix;
  logic [DATA_W-1:0] r_data;

  // Raster counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  assign w_active = (r_v_cnt >= V_START) && (r_v_cnt <= V_END) &&
                    (r_h_cnt >= H_START) && (r_h_cnt <= H_END);

  // Request stage; v-sync only re-evaluated at line start so its edges stay line-aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req  <= 1'b0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_fs   <= 1'b0;
      r_px_x <= '0;
      r_px_y <= '0;
    end else begin
      r_req <= w_active;
      r_hs  <= (r_h_cnt < H_SW);
      r_fs  <= (r_h_cnt == '0) && (r_v_cnt == '0);
      if (r_h_cnt == '0) r_vs <= (r_v_cnt < V_SW);
      if (w_active) begin
        r_px_x <= r_h_cnt - H_START;
        r_px_y <= r_v_cnt - V_START;
      end
    end
  end

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  assign w_stage = {3'(r_px_x / BAR_W), r_fs, r_req, r_vs, r_hs};
`else
  assign w_stage = {r_fs, r_req, r_vs, r_hs};
`endif

  // Look-ahead delay line from request stage to output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LOOKAHEAD; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_stage;
      for (int unsigned i = 1; i < LOOKAHEAD; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  generate
    if (LOOKAHEAD == 1) begin : g_pre_direct
      assign w_pre = w_stage;
    end else begin : g_pre_dly
      assign w_pre = r_dly[LOOKAHEAD-2];
    end
  endgenerate

  assign w_out = r_dly[LOOKAHEAD-1];

`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
  logic [23:0] w_bar_rgb;
  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_pre[6:4])
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end
  assign w_pix = pattern_sel ? DATA_W'(w_bar_rgb) : pix_in;
`else
  assign w_pix = pix_in;
`endif

  // Pixel capture one cycle ahead of data_en so data lines up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_data <= '0;
    else      r_data <= w_pre[AC_B] ? w_pix : '0;
  end

  assign px_req      = r_req;
  assign px_x        = r_px_x;
  assign px_y        = r_px_y;
  assign data        = r_data;
  assign data_en     = w_out[AC_B];
  assign frame_start = w_out[FS_B];
  assign h_sync      = w_out[HS_B] ? HS_POL : ~HS_POL;
  assign v_sync      = w_out[VS_B] ? VS_POL : ~VS_POL;
  assign clk_out     = clk;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster with inverted sync polarity.
module tb_video_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HS + HB + HA + HF;
  localparam int unsigned VT = VS + VB + VA + VF;
  localparam int FT = int'(HT * VT);
  localparam int LA = 2;
  localparam int unsigned CW = 12, DW = 24;
  localparam bit HP = 1'b0, VP = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tb_pat = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          px_req, data_en, h_sync, v_sync, frame_start, clk_out;
  logic [CW-1:0] px_x, px_y;
  logic [DW-1:0] data;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .DATA_W(DW), .CNT_W(CW), .LOOKAHEAD(LA)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef VIDEO_TIMING_GEN_TEST_PATTERN_EN
    .pattern_sel(tb_pat),
`endif
    .pix_in(pix_in), .px_req(px_req), .px_x(px_x), .px_y(px_y),
    .data(data), .data_en(data_en), .h_sync(h_sync), .v_sync(v_sync),
    .frame_start(frame_start), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int n = 0;
  int pops = 0;
  logic [DW-1:0] sbq[$];
  logic [DW-1:0] mem [VA][HA];
  logic [DW-1:0] pend;
  int m_lx = 0, m_ly = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d t=%0t", name, got, exp, n, $time);
    end
  endtask

  // Raster position of linear clock index within a frame
  function automatic int m_h(input int idx);
    return (idx % FT) % int'(HT);
  endfunction
  function automatic int m_v(input int idx);
    return (idx % FT) / int'(HT);
  endfunction
  function automatic bit m_act(input int idx);
    int h, v;
    if (idx < 0) return 1'b0;
    h = m_h(idx);
    v = m_v(idx);
    return (v >= int'(VS + VB)) && (v < int'(VS + VB + VA)) &&
           (h >= int'(HS + HB)) && (h < int'(HS + HB + HA));
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_px_req"}, 32'(px_req), 32'd0);
    chk({tag, "_px_x"}, 32'(px_x), 32'd0);
    chk({tag, "_px_y"}, 32'(px_y), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'd0);
    chk({tag, "_data_en"}, 32'(data_en), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_h_sync"}, 32'(h_sync), 32'(!HP));
    chk({tag, "_v_sync"}, 32'(v_sync), 32'(!VP));
  endtask

  // Monitor: per-cycle timing model and scoreboard pop on data_en
  always @(negedge clk) begin
    int q, p;
    logic e;
    if (!rst) begin
      chk_reset_vals("rst");
      m_lx = 0;
      m_ly = 0;
      pops = 0;
    end else begin
      q = n - 1;
      p = n - 1 - LA;
      if (m_act(q)) begin
        m_lx = m_h(q) - int'(HS + HB);
        m_ly = m_v(q) - int'(VS + VB);
      end
      chk("px_req", 32'(px_req), 32'(m_act(q)));
      chk("px_x", 32'(px_x), 32'(m_lx));
      chk("px_y", 32'(px_y), 32'(m_ly));
      chk("data_en", 32'(data_en), 32'(m_act(p)));
      e = (p >= 0 && m_h(p) < int'(HS)) ? HP : !HP;
      chk("h_sync", 32'(h_sync), 32'(e));
      e = (p >= 0 && m_v(p) < int'(VS)) ? VP : !VP;
      chk("v_sync", 32'(v_sync), 32'(e));
      chk("frame_start", 32'(frame_start), 32'(p >= 0 && (p % FT) == 0));
      if (data_en) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'(1), 32'(0));
        end else begin
          chk("data", 32'(data), 32'(sbq.pop_front()));
          pops++;
        end
      end else begin
        chk("data_idle", 32'(data), 32'd0);
      end
    end
  end

  // Stimulus: pixel source with one cycle of latency; expected pixels queued per frame
  task automatic run(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (((n - 1) % FT) == 0) begin
        for (int y = 0; y < int'(VA); y++)
          for (int x = 0; x < int'(HA); x++) begin
            mem[y][x] = DW'($urandom);
            sbq.push_back(mem[y][x]);
          end
      end
      pix_in = pend;
      if (px_req && px_x < CW'(HA) && px_y < CW'(VA)) pend = mem[px_y][px_x];
      else pend = DW'($urandom);
    end
  endtask

  initial begin
    pend = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    run(3 * FT + 2 * int'(HT) + 5 + int'($urandom_range(0, 6)));
    chk("pre_reset_px_req", 32'(px_req), 32'd1);
    rst = 1'b0;
    #1 chk_reset_vals("async");
    repeat (3) @(negedge clk);
    sbq.delete();
    n = 0;
    pend = '0;
    #1 rst = 1'b1;
    run(2 * FT);
    @(negedge clk);
    #1;
    chk("total_data_en", 32'(pops), 32'(2 * VA * HA));
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
